// File: rtl/bnn_pkg.sv
`default_nettype none
// bnn_pkg: shared widths, frame geometry, FSM encoding and helpers for the BNN post-conv stage.
// Rev 1.0
package bnn_pkg;
  localparam int DW       = 32;
  localparam int OW       = 16;
  localparam int W0       = 24;
  localparam int W1       = 8;
  localparam int WIN_DLY0 = 10;
  localparam int WIN_DLY1 = 90;

  localparam int WMAX   = (W0 > W1) ? W0 : W1;
  localparam int CW     = $clog2(WMAX * WMAX + 1);
  localparam int LBD    = WMAX / 2;
  localparam int LBW    = $clog2(LBD);
  localparam int DLYMAX = (WIN_DLY0 > WIN_DLY1) ? WIN_DLY0 : WIN_DLY1;
  localparam int DLYW   = $clog2(DLYMAX + 1);

  localparam logic signed [DW-1:0] QMAX = DW'((1 << (OW - 1)) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  function automatic logic [CW-1:0] layer_width(input logic l);
    return l ? CW'(W1) : CW'(W0);
  endfunction

  function automatic logic [DLYW-1:0] layer_dly(input logic l);
    return l ? DLYW'(WIN_DLY1) : DLYW'(WIN_DLY0);
  endfunction

  // ReLU, arithmetic right shift, then clamp to the positive OW-bit range.
  function automatic logic [OW-1:0] relu_quant(input logic signed [DW-1:0] d, input logic [4:0] sh);
    logic signed [DW-1:0] q;
    q = d >>> sh;
    if (d < 0)
      return '0;
    else if (q > QMAX)
      return QMAX[OW-1:0];
    else
      return q[OW-1:0];
  endfunction
endpackage
`default_nettype wire

// File: rtl/conv_post_pool_if.sv
`default_nettype none
// conv_post_pool_if: control, conv-input and pooled-output signals of the post-conv stage.
// Rev 1.0
interface conv_post_pool_if;
  import bnn_pkg::*;

  logic          start;
  logic          layer;
  logic [4:0]    shift;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          win_start;
  logic          busy;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          done;
  logic          overrun;

  modport master (
    output start, layer, shift, in_valid, in_data,
    input  win_start, busy, out_valid, out_data, done, overrun
  );

  modport slave (
    input  start, layer, shift, in_valid, in_data,
    output win_start, busy, out_valid, out_data, done, overrun
  );
endinterface
`default_nettype wire

// File: rtl/pool2x2_line.sv
`default_nettype none
// pool2x2_line: 2x2/stride-2 max pool over a raster stream using a half-row line buffer.
// Rev 1.0
module pool2x2_line import bnn_pkg::*; (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear_i,
  input  logic          valid_i,
  input  logic [OW-1:0] data_i,
  input  logic [CW-1:0] width_i,
  output logic          valid_o,
  output logic          last_o,
  output logic [OW-1:0] data_o
);
  logic [CW-1:0]  col_q;
  logic [CW-1:0]  row_q;
  logic [OW-1:0]  prev_q;
  logic [OW-1:0]  lbuf_q [LBD];
  logic           valid_q;
  logic           last_q;
  logic [OW-1:0]  data_q;

  logic [LBW-1:0] idx;
  logic [OW-1:0]  pair_max;
  logic [OW-1:0]  out_max;
  logic           col_last;
  logic           row_last;

  assign idx      = col_q[LBW:1];
  assign col_last = (col_q == width_i - 1'b1);
  assign row_last = (row_q == width_i - 1'b1);
  assign pair_max = ($signed(prev_q) > $signed(data_i)) ? prev_q : data_i;
  assign out_max  = ($signed(lbuf_q[idx]) > $signed(pair_max)) ? lbuf_q[idx] : pair_max;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q   <= '0;
      row_q   <= '0;
      prev_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      for (int i = 0; i < LBD; i++) lbuf_q[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      if (clear_i) begin
        col_q <= '0;
        row_q <= '0;
      end else if (valid_i) begin
        // Even column holds the left half of the pair; odd column resolves it.
        if (!col_q[0]) begin
          prev_q <= data_i;
        end else if (!row_q[0]) begin
          lbuf_q[idx] <= pair_max;
        end else begin
          valid_q <= 1'b1;
          data_q  <= out_max;
          last_q  <= row_last && col_last;
        end
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign data_o  = data_q;
endmodule
`default_nettype wire

// File: rtl/conv_post_pool.sv
`default_nettype none
// conv_post_pool: frame sequencer, ReLU/quantise stage and pool wrapper after the conv engine.
// Rev 1.0
module conv_post_pool import bnn_pkg::*; (
  input  logic             clk,
  input  logic             rstn,
  conv_post_pool_if.slave  bus
);
  state_e          state_q, state_d;
  logic            layer_q;
  logic [4:0]      shift_q;
  logic [DLYW-1:0] dly_q, dly_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d;
  logic            overrun_q, overrun_d;
  logic            s1_valid_q;
  logic [OW-1:0]   s1_data_q;

  logic [CW-1:0]   width;
  logic [CW-1:0]   frame_len;
  logic            accept_start;
  logic            accept_in;
  logic            pool_valid;
  logic            pool_last;
  logic [OW-1:0]   pool_data;

  assign width        = layer_width(layer_q);
  assign frame_len    = width * width;
  assign accept_start = (state_q == S_IDLE) && bus.start;
  assign accept_in    = (state_q == S_RUN) && bus.in_valid;

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    in_cnt_d  = in_cnt_q;
    overrun_d = overrun_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_DELAY;
          dly_d    = '0;
          in_cnt_d = '0;
        end
      end
      S_DELAY: begin
        if (dly_q == layer_dly(layer_q) - 1'b1) state_d = S_RUN;
        else                                    dly_d   = dly_q + 1'b1;
      end
      S_RUN: begin
        if (bus.in_valid) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == frame_len - 1'b1) state_d = S_FLUSH;
        end
      end
      S_FLUSH: if (pool_valid && pool_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept_start)                            overrun_d = 1'b0;
    else if (bus.in_valid && state_q != S_RUN)   overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      layer_q    <= 1'b0;
      shift_q    <= '0;
      dly_q      <= '0;
      in_cnt_q   <= '0;
      overrun_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      in_cnt_q   <= in_cnt_d;
      overrun_q  <= overrun_d;
      s1_valid_q <= accept_in;
      if (accept_start) begin
        layer_q <= bus.layer;
        shift_q <= bus.shift;
      end
      if (accept_in) s1_data_q <= relu_quant($signed(bus.in_data), shift_q);
    end
  end

  pool2x2_line u_pool (
    .clk     (clk),
    .rstn    (rstn),
    .clear_i (accept_start),
    .valid_i (s1_valid_q),
    .data_i  (s1_data_q),
    .width_i (width),
    .valid_o (pool_valid),
    .last_o  (pool_last),
    .data_o  (pool_data)
  );

  assign bus.win_start = (state_q == S_RUN);
  assign bus.busy      = (state_q == S_DELAY) || (state_q == S_RUN) || (state_q == S_FLUSH);
  assign bus.done      = (state_q == S_DONE);
  assign bus.out_valid = pool_valid;
  assign bus.out_data  = pool_data;
  assign bus.overrun   = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_conv_post_pool.sv
`default_nettype none
// tb_conv_post_pool: directed and randomised frames checked against a block-max reference model.
// Rev 1.0
module tb_conv_post_pool;
  logic clk;
  logic rstn;
  int   cyc;
  int   n_assert;
  int   n_fail;

  conv_post_pool_if ifc ();

  conv_post_pool dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int stim_q[$];
  int exp_q[$];
  int got_q[$];
  int ws_rise_cyc, last_ov_cyc, done_cyc, done_cnt, start_cyc;
  logic busy_lastov, busy_done, ws_prev;

  always @(negedge clk) begin
    if (ifc.out_valid === 1'b1) begin
      got_q.push_back(int'(ifc.out_data));
      last_ov_cyc = cyc;
      busy_lastov = ifc.busy;
    end
    if (ifc.done === 1'b1) begin
      done_cnt++;
      done_cyc  = cyc;
      busy_done = ifc.busy;
    end
    if (ifc.win_start === 1'b1 && ws_prev !== 1'b1 && ws_rise_cyc < 0) ws_rise_cyc = cyc;
    ws_prev = ifc.win_start;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i >= 0 && i < got_q.size()) return got_q[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic int quant(input int v, input int sh);
    int q;
    if (v < 0) return 0;
    q = v >>> sh;
    return (q > 32767) ? 32767 : q;
  endfunction

  // Each output is the maximum of one quantised 2x2 block, blocks in raster order.
  function automatic void build_expected(input int w, input int sh);
    exp_q.delete();
    for (int br = 0; br < w / 2; br++)
      for (int bc = 0; bc < w / 2; bc++) begin
        int m;
        m = 0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++) begin
            int v;
            v = quant(stim_q[(2 * br + dr) * w + 2 * bc + dc], sh);
            if (v > m) m = v;
          end
        exp_q.push_back(m);
      end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input bit lyr, input int sh);
    ifc.start = 1'b1;
    ifc.layer = lyr;
    ifc.shift = 5'(sh);
    tick();
    start_cyc = cyc;
    ifc.start = 1'b0;
  endtask

  task automatic wait_win(input string tag);
    int n;
    n = 0;
    while (ifc.win_start !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check({tag, " win_start timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_frame(input string tag, input bit lyr, input int sh, input bit gaps, input bit junk);
    int w, dly, n;
    w   = lyr ? 8 : 24;
    dly = lyr ? 90 : 10;
    build_expected(w, sh);
    got_q.delete();
    ws_rise_cyc = -1;
    last_ov_cyc = -1;
    done_cyc    = -1;
    done_cnt    = 0;
    start_frame(lyr, sh);
    if (junk) begin
      repeat (3) begin
        ifc.in_valid = 1'b1;
        ifc.in_data  = $urandom;
        tick();
      end
      ifc.in_valid = 1'b0;
    end
    wait_win(tag);
    foreach (stim_q[i]) begin
      int g;
      g = gaps ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0) : 0;
      repeat (g) begin
        ifc.in_valid = 1'b0;
        ifc.in_data  = $urandom;
        ifc.start    = 1'($urandom_range(0, 1));
        ifc.layer    = 1'($urandom_range(0, 1));
        ifc.shift    = 5'($urandom_range(0, 31));
        tick();
      end
      ifc.start    = 1'b0;
      ifc.in_valid = 1'b1;
      ifc.in_data  = stim_q[i];
      tick();
    end
    ifc.in_valid = 1'b0;
    ifc.start    = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    check({tag, " win_start delay"}, 32'(ws_rise_cyc - start_cyc), 32'(dly));
    check({tag, " output count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s out[%0d]", tag, i), got_at(i), 32'(exp_q[i]));
    check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " done after last out"}, 32'(done_cyc - last_ov_cyc), 32'd1);
    check({tag, " busy at last out"}, {31'd0, busy_lastov}, 32'd1);
    check({tag, " busy at done"}, {31'd0, busy_done}, 32'd0);
    check({tag, " win_start idle"}, {31'd0, ifc.win_start}, 32'd0);
    check({tag, " overrun"}, {31'd0, ifc.overrun}, {31'd0, junk});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " win_start"}, {31'd0, ifc.win_start}, 32'd0);
    check({tag, " busy"}, {31'd0, ifc.busy}, 32'd0);
    check({tag, " out_valid"}, {31'd0, ifc.out_valid}, 32'd0);
    check({tag, " out_data"}, {16'd0, ifc.out_data}, 32'd0);
    check({tag, " done"}, {31'd0, ifc.done}, 32'd0);
    check({tag, " overrun"}, {31'd0, ifc.overrun}, 32'd0);
  endtask

  task automatic fill_ramp(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(i);
  endtask

  task automatic fill_const(input int n, input int v);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(v);
  endtask

  initial begin
    cyc = 0; n_assert = 0; n_fail = 0; ws_prev = 1'b0;
    ifc.start = 1'b0; ifc.layer = 1'b0; ifc.shift = '0; ifc.in_valid = 1'b0; ifc.in_data = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    tick();
    check_all_zero("post-reset");

    fill_ramp(576);
    run_frame("ramp24", 1'b0, 0, 1'b0, 1'b0);
    check("ramp24 first", got_at(0), 32'd25);
    check("ramp24 second", got_at(1), 32'd27);
    check("ramp24 last", got_at(143), 32'd575);

    fill_const(576, -5);
    run_frame("neg24", 1'b0, 0, 1'b0, 1'b0);

    fill_const(64, 32'h0001_0000);
    run_frame("sat s0", 1'b1, 0, 1'b0, 1'b0);
    check("sat s0 value", got_at(0), 32'd32767);
    run_frame("sat s4", 1'b1, 4, 1'b0, 1'b0);
    check("sat s4 value", got_at(0), 32'd4096);

    fill_ramp(64);
    run_frame("ramp8", 1'b1, 0, 1'b0, 1'b0);
    check("ramp8 first", got_at(0), 32'd9);
    check("ramp8 last", got_at(15), 32'd63);

    fill_ramp(576);
    run_frame("gaps24", 1'b0, 0, 1'b1, 1'b1);
    check("gaps24 first", got_at(0), 32'd25);
    check("gaps24 last", got_at(143), 32'd575);

    for (int f = 0; f < 4; f++) begin
      stim_q.delete();
      for (int i = 0; i < 64; i++) begin
        case ($urandom_range(0, 2))
          0:       stim_q.push_back(int'($urandom));
          1:       stim_q.push_back(int'($urandom_range(0, 70000)));
          default: stim_q.push_back(-int'($urandom_range(0, 1000)));
        endcase
      end
      run_frame($sformatf("rand%0d", f), 1'b1, int'($urandom_range(0, 20)), f[0], 1'b0);
    end

    fill_ramp(576);
    start_frame(1'b0, 0);
    wait_win("abort");
    for (int i = 0; i < 300; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = i;
      tick();
    end
    rstn = 1'b0;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    check_all_zero("abort reset");
    tick();
    rstn = 1'b1;
    tick();
    run_frame("recover24", 1'b0, 0, 1'b0, 1'b0);
    check("recover24 first", got_at(0), 32'd25);
    check("recover24 last", got_at(143), 32'd575);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
